// File: rtl/xgri_pkg.sv
// xgri_pkg: shared definitions for the multi-channel CPU-to-graphics
// write-queue interface (xgri_mc).
//   - per-channel register offsets (ri_addr[1:0])
//   - STATUS/CTRL bit positions
//   - queue entry layout {addr, data}, sized for the widest configuration
package xgri_pkg;

  // Register offsets within one channel
  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_ADDR   = 2'd1;
  localparam logic [1:0] REG_STRIDE = 2'd2;
  localparam logic [1:0] REG_DATA   = 2'd3;

  // STATUS read / CTRL write bit positions
  localparam int ST_EMPTY  = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_OVF    = 2;
  localparam int ST_PEND   = 3;
  localparam int ST_IRQ_EN = 4;
  localparam int ST_LEVEL  = 8;

  localparam int MAX_ADDR_W = 16;
  localparam int XGRI_DATA_W = 16;

  // One queued write: target address and data word
  typedef struct packed {
    logic [MAX_ADDR_W-1:0]  addr;
    logic [XGRI_DATA_W-1:0] data;
  } xgri_entry_t;

endpackage

// File: rtl/xgri_fifo.sv
// xgri_fifo: single-clock show-ahead FIFO.
// Ports:
//   clk_sys, rst_n   clock, synchronous active-low reset
//   push, wdata      write request and data
//   pop              read request (ignored while empty)
//   rdata            head entry, zero while empty
//   full, empty      occupancy flags
//   level            number of stored entries (0..DEPTH)
//   push_ok, pop_ok  this cycle's push/pop is actually performed
// A push into a full FIFO is still accepted when a pop happens in the
// same cycle, since the head slot frees up at the same edge.
module xgri_fifo #(
  parameter  int WIDTH = 29,
  parameter  int DEPTH = 16,
  localparam int PW    = $clog2(DEPTH),
  localparam int LW    = PW + 1
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level,
  output logic             push_ok,
  output logic             pop_ok
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [LW-1:0]    count_r;

  assign empty   = (count_r == LW'(0));
  assign full    = (count_r == LW'(DEPTH));
  assign level   = count_r;
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop);
  assign rdata   = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

  // Entry storage; no reset needed because rdata is masked while empty
  always_ff @(posedge clk_sys) begin
    if (push_ok) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {LW{1'b0}};
    end else begin
      if (push_ok) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_r + LW'(push_ok) - LW'(pop_ok);
    end
  end

endmodule

// File: rtl/xgri_mc.sv
// xgri_mc: multi-channel CPU-to-graphics write queue.
// The CPU programs per-channel ADDR/STRIDE and pushes data words through
// the DATA register; each word is queued with the current ADDR, which then
// advances by STRIDE. The consumer drains each channel via valid/pop.
// Ports:
//   clk_sys, rst_n           clock, synchronous active-low reset
//   ri_en/ri_wren/ri_ren     register interface select and strobes
//   ri_addr                  [3:2] channel, [1:0] register
//   from_cpu / to_cpu        write data / registered read data
//   ch_valid/ch_pop          per-channel head valid and pop
//   ch_data/ch_addr          per-channel head entry, packed by channel
//   irq                      OR of (irq_pend & irq_en), registered
module xgri_mc
  import xgri_pkg::*;
#(
  parameter  int NUM_CH     = 2,
  parameter  int DATA_W     = 16,
  parameter  int ADDR_W     = 13,
  parameter  int FIFO_DEPTH = 16,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk_sys,
  input  logic                     rst_n,
  input  logic                     ri_en,
  input  logic                     ri_wren,
  input  logic                     ri_ren,
  input  logic [3:0]               ri_addr,
  input  logic [DATA_W-1:0]        from_cpu,
  output logic [15:0]              to_cpu,
  output logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH-1:0]        ch_pop,
  output logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH*ADDR_W-1:0] ch_addr,
  output logic                     irq
);

  logic                     wr_s;
  logic                     rd_s;
  logic [1:0]               sel_ch_s;
  logic [1:0]               sel_reg_s;
  logic [NUM_CH-1:0]        ctrl_wr_s;
  logic [NUM_CH-1:0]        addr_wr_s;
  logic [NUM_CH-1:0]        stride_wr_s;
  logic [NUM_CH-1:0]        push_req_s;
  logic [NUM_CH-1:0]        push_ok_s;
  logic [NUM_CH-1:0]        pop_ok_s;
  logic [NUM_CH-1:0]        full_s;
  logic [NUM_CH-1:0]        empty_s;
  logic [NUM_CH-1:0]        drain_s;
  logic [LW-1:0]            level_s [NUM_CH];
  logic [ADDR_W+DATA_W-1:0] rdata_s [NUM_CH];
  logic [15:0]              ch_word_s [NUM_CH];
  logic [15:0]              rd_mux_s;

  logic [ADDR_W-1:0]        addr_r   [NUM_CH];
  logic [ADDR_W-1:0]        stride_r [NUM_CH];
  logic [NUM_CH-1:0]        ovf_r;
  logic [NUM_CH-1:0]        pend_r;
  logic [NUM_CH-1:0]        en_r;
  logic [15:0]              to_cpu_r;
  logic                     irq_r;

  assign wr_s      = ri_en & ri_wren;
  assign rd_s      = ri_en & ri_ren;
  assign sel_ch_s  = ri_addr[3:2];
  assign sel_reg_s = ri_addr[1:0];

  // Per-channel write decode; channel numbers >= NUM_CH match nothing
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ctrl_wr_s[c]   = wr_s && (sel_ch_s == 2'(c)) && (sel_reg_s == REG_STATUS);
      addr_wr_s[c]   = wr_s && (sel_ch_s == 2'(c)) && (sel_reg_s == REG_ADDR);
      stride_wr_s[c] = wr_s && (sel_ch_s == 2'(c)) && (sel_reg_s == REG_STRIDE);
      push_req_s[c]  = wr_s && (sel_ch_s == 2'(c)) && (sel_reg_s == REG_DATA);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    xgri_fifo #(
      .WIDTH (ADDR_W + DATA_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_sys (clk_sys),
      .rst_n   (rst_n),
      .push    (push_req_s[c]),
      .wdata   ({addr_r[c], from_cpu}),
      .pop     (ch_pop[c]),
      .rdata   (rdata_s[c]),
      .full    (full_s[c]),
      .empty   (empty_s[c]),
      .level   (level_s[c]),
      .push_ok (push_ok_s[c]),
      .pop_ok  (pop_ok_s[c])
    );

    assign ch_valid[c]                 = ~empty_s[c];
    assign ch_data[c*DATA_W +: DATA_W] = rdata_s[c][DATA_W-1:0];
    assign ch_addr[c*ADDR_W +: ADDR_W] = rdata_s[c][ADDR_W+DATA_W-1:DATA_W];

    // Level goes 1 -> 0: the last entry leaves with nothing replacing it
    assign drain_s[c] = pop_ok_s[c] & ~push_ok_s[c] & (level_s[c] == LW'(1));
  end

  // Per-channel ADDR/STRIDE and sticky flags; set events win over clears
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        addr_r[c]   <= {ADDR_W{1'b0}};
        stride_r[c] <= ADDR_W'(1);
      end
      ovf_r  <= {NUM_CH{1'b0}};
      pend_r <= {NUM_CH{1'b0}};
      en_r   <= {NUM_CH{1'b0}};
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (addr_wr_s[c]) begin
          addr_r[c] <= from_cpu[ADDR_W-1:0];
        end else if (push_ok_s[c]) begin
          addr_r[c] <= addr_r[c] + stride_r[c];
        end
        if (stride_wr_s[c]) begin
          stride_r[c] <= from_cpu[ADDR_W-1:0];
        end
        if (push_req_s[c] && !push_ok_s[c]) begin
          ovf_r[c] <= 1'b1;
        end else if (ctrl_wr_s[c] && from_cpu[ST_OVF]) begin
          ovf_r[c] <= 1'b0;
        end
        if (drain_s[c]) begin
          pend_r[c] <= 1'b1;
        end else if (ctrl_wr_s[c] && from_cpu[ST_PEND]) begin
          pend_r[c] <= 1'b0;
        end
        if (ctrl_wr_s[c]) begin
          en_r[c] <= from_cpu[ST_IRQ_EN];
        end
      end
    end
  end

  // Per-channel readback word, taken from pre-edge state
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      case (sel_reg_s)
        REG_STATUS: ch_word_s[c] = {8'(level_s[c]), 3'b000, en_r[c], pend_r[c],
                                    ovf_r[c], full_s[c], empty_s[c]};
        REG_ADDR:   ch_word_s[c] = 16'(addr_r[c]);
        REG_STRIDE: ch_word_s[c] = 16'(stride_r[c]);
        default:    ch_word_s[c] = 16'h0000;
      endcase
    end
  end

  // AND-OR channel select; unimplemented channels read as zero
  always_comb begin
    rd_mux_s = 16'h0000;
    for (int c = 0; c < NUM_CH; c++) begin
      rd_mux_s = rd_mux_s | (ch_word_s[c] & {16{sel_ch_s == 2'(c)}});
    end
  end

  // Read-data register; holds its value between reads
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      to_cpu_r <= 16'h0000;
    end else if (rd_s) begin
      to_cpu_r <= rd_mux_s;
    end
  end

  // Registered interrupt
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= |(pend_r & en_r);
    end
  end

  assign to_cpu = to_cpu_r;
  assign irq    = irq_r;

endmodule

// File: tb/tb_xgri_mc.sv
// tb_xgri_mc: directed and randomized bench for xgri_mc (2 channels,
// 13-bit addresses, 16-deep queues) with a queue-based reference model.
module tb_xgri_mc;

  localparam int NCH   = 2;
  localparam int AW    = 13;
  localparam int DW    = 16;
  localparam int DEPTH = 16;

  logic              clk_sys  = 1'b0;
  logic              rst_n    = 1'b0;
  logic              ri_en    = 1'b0;
  logic              ri_wren  = 1'b0;
  logic              ri_ren   = 1'b0;
  logic [3:0]        ri_addr  = 4'h0;
  logic [15:0]       from_cpu = 16'h0000;
  logic [15:0]       to_cpu;
  logic [NCH-1:0]    ch_valid;
  logic [NCH-1:0]    ch_pop   = '0;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH*AW-1:0] ch_addr;
  logic              irq;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_sys = ~clk_sys;

  xgri_mc #(
    .NUM_CH     (NCH),
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .ri_en    (ri_en),
    .ri_wren  (ri_wren),
    .ri_ren   (ri_ren),
    .ri_addr  (ri_addr),
    .from_cpu (from_cpu),
    .to_cpu   (to_cpu),
    .ch_valid (ch_valid),
    .ch_pop   (ch_pop),
    .ch_data  (ch_data),
    .ch_addr  (ch_addr),
    .irq      (irq)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t        mq [NCH][$];
  logic [AW-1:0] m_addr [NCH];
  logic [AW-1:0] m_stride [NCH];
  bit          m_ovf [NCH];
  bit          m_pend [NCH];
  bit          m_en [NCH];
  bit          m_irq;
  logic [15:0] m_rd;

  task automatic model_reset;
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      m_addr[c]   = '0;
      m_stride[c] = AW'(1);
      m_ovf[c]    = 1'b0;
      m_pend[c]   = 1'b0;
      m_en[c]     = 1'b0;
    end
    m_irq = 1'b0;
    m_rd  = 16'h0000;
  endtask

  // One clock of the register/queue rules, from the state before the edge
  task automatic model_cycle(input bit we, input bit re, input logic [3:0] a,
                             input logic [15:0] d, input logic [NCH-1:0] pops);
    int  ch;
    int  rg;
    int  sz;
    bit  pushr, popeff, pacc, ctrlw;
    bit  nxt_irq;
    ent_t e;
    ch = int'(a[3:2]);
    rg = int'(a[1:0]);
    if (re) begin
      m_rd = 16'h0000;
      if (ch < NCH) begin
        sz = mq[ch].size();
        case (rg)
          0: m_rd = {8'(sz), 3'b000, m_en[ch], m_pend[ch], m_ovf[ch],
                     (sz == DEPTH), (sz == 0)};
          1: m_rd = 16'(m_addr[ch]);
          2: m_rd = 16'(m_stride[ch]);
          default: m_rd = 16'h0000;
        endcase
      end
    end
    nxt_irq = 1'b0;
    for (int c = 0; c < NCH; c++) nxt_irq |= (m_pend[c] && m_en[c]);
    for (int c = 0; c < NCH; c++) begin
      sz     = mq[c].size();
      pushr  = we && (rg == 3) && (ch == c);
      ctrlw  = we && (rg == 0) && (ch == c);
      popeff = pops[c] && (sz > 0);
      pacc   = pushr && ((sz < DEPTH) || pops[c]);
      if (pushr && !pacc) m_ovf[c] = 1'b1;
      else if (ctrlw && d[2]) m_ovf[c] = 1'b0;
      if (popeff && (sz == 1) && !pacc) m_pend[c] = 1'b1;
      else if (ctrlw && d[3]) m_pend[c] = 1'b0;
      if (ctrlw) m_en[c] = d[4];
      e.a = m_addr[c];
      e.d = d;
      if (we && (rg == 1) && (ch == c)) m_addr[c] = d[AW-1:0];
      else if (pacc) m_addr[c] = m_addr[c] + m_stride[c];
      if (we && (rg == 2) && (ch == c)) m_stride[c] = d[AW-1:0];
      if (popeff) void'(mq[c].pop_front());
      if (pacc) mq[c].push_back(e);
    end
    m_irq = nxt_irq;
  endtask

  // ---------------- stimulus primitives ----------------
  task automatic step(input bit we, input bit re, input logic [3:0] a,
                      input logic [15:0] d, input logic [NCH-1:0] pops);
    ri_en    = we | re;
    ri_wren  = we;
    ri_ren   = re;
    ri_addr  = a;
    from_cpu = d;
    ch_pop   = pops;
    model_cycle(we, re, a, d, pops);
    @(posedge clk_sys);
    #1;
    ri_en   = 1'b0;
    ri_wren = 1'b0;
    ri_ren  = 1'b0;
    ch_pop  = '0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    step(1'b1, 1'b0, a, d, '0);
  endtask

  task automatic rd(input logic [3:0] a, output logic [15:0] v);
    step(1'b0, 1'b1, a, 16'h0000, '0);
    v = to_cpu;
  endtask

  task automatic pop0;
    step(1'b0, 1'b0, 4'h0, 16'h0000, 2'b01);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    @(posedge clk_sys);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic [15:0] v;
    do_reset();
    n_cmp++; if (ch_valid !== 2'b00) begin n_bad++; $display("FAIL reset_valid got %b want 00", ch_valid); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got %b want 0", irq); end
    n_cmp++; if (to_cpu !== 16'h0000) begin n_bad++; $display("FAIL reset_to_cpu got %h want 0000", to_cpu); end
    n_cmp++; if (ch_data !== '0 || ch_addr !== '0) begin n_bad++; $display("FAIL reset_head got %h/%h want 0/0", ch_data, ch_addr); end
    rd(4'h0, v);
    n_cmp++; if (v !== 16'h0001) begin n_bad++; $display("FAIL reset_status got %h want 0001", v); end
    rd(4'h2, v);
    n_cmp++; if (v !== 16'h0001) begin n_bad++; $display("FAIL reset_stride0 got %h want 0001", v); end
    rd(4'h6, v);
    n_cmp++; if (v !== 16'h0001) begin n_bad++; $display("FAIL reset_stride1 got %h want 0001", v); end
  endtask

  task automatic test_stride_stream;
    logic [15:0] v;
    logic [15:0] exp_d [3];
    logic [12:0] exp_a [3];
    exp_d[0] = 16'hAAAA; exp_d[1] = 16'hBBBB; exp_d[2] = 16'hCCCC;
    exp_a[0] = 13'h0100; exp_a[1] = 13'h0104; exp_a[2] = 13'h0108;
    wr(4'h1, 16'h0100);
    wr(4'h2, 16'h0004);
    for (int i = 0; i < 3; i++) wr(4'h3, exp_d[i]);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (ch_valid[0] !== 1'b1 || ch_data[15:0] !== exp_d[i] || ch_addr[12:0] !== exp_a[i]) begin
        n_bad++;
        $display("FAIL stride_head%0d got v=%b %h@%h want 1 %h@%h", i, ch_valid[0], ch_data[15:0], ch_addr[12:0], exp_d[i], exp_a[i]);
      end
      pop0();
    end
    n_cmp++; if (ch_valid[0] !== 1'b0) begin n_bad++; $display("FAIL stride_drained got %b want 0", ch_valid[0]); end
    rd(4'h1, v);
    n_cmp++; if (v !== 16'h010C) begin n_bad++; $display("FAIL stride_addr got %h want 010C", v); end
  endtask

  task automatic test_overflow;
    logic [15:0] v;
    wr(4'h0, 16'h000C);
    for (int i = 0; i < 17; i++) wr(4'h3, 16'h5000 + 16'(i));
    rd(4'h0, v);
    n_cmp++; if (v !== 16'h1006) begin n_bad++; $display("FAIL ovf_status got %h want 1006", v); end
    rd(4'h1, v);
    n_cmp++; if (v !== 16'h014C) begin n_bad++; $display("FAIL ovf_addr got %h want 014C", v); end
    n_cmp++; if (ch_data[15:0] !== 16'h5000 || ch_addr[12:0] !== 13'h010C) begin n_bad++; $display("FAIL ovf_head got %h@%h want 5000@010C", ch_data[15:0], ch_addr[12:0]); end
    wr(4'h0, 16'h0004);
    rd(4'h0, v);
    n_cmp++; if (v !== 16'h1002) begin n_bad++; $display("FAIL ovf_clear got %h want 1002", v); end
  endtask

  task automatic test_full_pop;
    logic [15:0] v;
    step(1'b1, 1'b0, 4'h3, 16'h7777, 2'b01);
    rd(4'h0, v);
    n_cmp++; if (v !== 16'h1002) begin n_bad++; $display("FAIL fullpop_status got %h want 1002", v); end
    n_cmp++; if (ch_data[15:0] !== 16'h5001 || ch_addr[12:0] !== 13'h0110) begin n_bad++; $display("FAIL fullpop_head got %h@%h want 5001@0110", ch_data[15:0], ch_addr[12:0]); end
    for (int i = 0; i < 15; i++) pop0();
    n_cmp++; if (ch_data[15:0] !== 16'h7777 || ch_addr[12:0] !== 13'h014C) begin n_bad++; $display("FAIL fullpop_last got %h@%h want 7777@014C", ch_data[15:0], ch_addr[12:0]); end
    pop0();
    n_cmp++; if (ch_valid[0] !== 1'b0) begin n_bad++; $display("FAIL fullpop_drained got %b want 0", ch_valid[0]); end
  endtask

  task automatic test_irq;
    logic [15:0] v;
    wr(4'h0, 16'h000C);
    wr(4'h0, 16'h0010);
    wr(4'h3, 16'h0001);
    wr(4'h3, 16'h0002);
    pop0();
    pop0();
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_early got %b want 0", irq); end
    step(1'b0, 1'b0, 4'h0, 16'h0000, '0);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_rise got %b want 1", irq); end
    rd(4'h0, v);
    n_cmp++; if (v !== 16'h0019) begin n_bad++; $display("FAIL irq_status got %h want 0019", v); end
    wr(4'h0, 16'h0018);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_lag got %b want 1", irq); end
    step(1'b0, 1'b0, 4'h0, 16'h0000, '0);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_fall got %b want 0", irq); end
    wr(4'h0, 16'h0008);
    wr(4'h3, 16'h0003);
    wr(4'h3, 16'h0004);
    pop0();
    pop0();
    step(1'b0, 1'b0, 4'h0, 16'h0000, '0);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_masked got %b want 0", irq); end
    rd(4'h0, v);
    n_cmp++; if (v !== 16'h0009) begin n_bad++; $display("FAIL irq_masked_status got %h want 0009", v); end
  endtask

  task automatic test_isolation_wrap;
    logic [15:0] v;
    wr(4'h5, 16'h1FFF);
    wr(4'h6, 16'h0002);
    wr(4'h7, 16'h1234);
    rd(4'h5, v);
    n_cmp++; if (v !== 16'h0001) begin n_bad++; $display("FAIL wrap_addr1 got %h want 0001", v); end
    n_cmp++; if (ch_data[31:16] !== 16'h1234 || ch_addr[25:13] !== 13'h1FFF) begin n_bad++; $display("FAIL wrap_head1 got %h@%h want 1234@1FFF", ch_data[31:16], ch_addr[25:13]); end
    rd(4'h1, v);
    n_cmp++; if (v !== 16'h0160) begin n_bad++; $display("FAIL iso_addr0 got %h want 0160", v); end
    rd(4'h2, v);
    n_cmp++; if (v !== 16'h0004) begin n_bad++; $display("FAIL iso_stride0 got %h want 0004", v); end
    wr(4'hC, 16'hFFFF);
    wr(4'hE, 16'h00FF);
    wr(4'hF, 16'hABCD);
    rd(4'hC, v);
    n_cmp++; if (v !== 16'h0000) begin n_bad++; $display("FAIL nochan_status got %h want 0000", v); end
    rd(4'hE, v);
    n_cmp++; if (v !== 16'h0000) begin n_bad++; $display("FAIL nochan_stride got %h want 0000", v); end
    n_cmp++; if (ch_valid !== 2'b10) begin n_bad++; $display("FAIL nochan_valid got %b want 10", ch_valid); end
    wr(4'h3, 16'h9999);
    n_cmp++; if (ch_valid !== 2'b11) begin n_bad++; $display("FAIL midrst_pre got %b want 11", ch_valid); end
    do_reset();
    n_cmp++; if (ch_valid !== 2'b00) begin n_bad++; $display("FAIL midrst_valid got %b want 00", ch_valid); end
    rd(4'h4, v);
    n_cmp++; if (v !== 16'h0001) begin n_bad++; $display("FAIL midrst_status1 got %h want 0001", v); end
    rd(4'h5, v);
    n_cmp++; if (v !== 16'h0000) begin n_bad++; $display("FAIL midrst_addr1 got %h want 0000", v); end
    rd(4'h6, v);
    n_cmp++; if (v !== 16'h0001) begin n_bad++; $display("FAIL midrst_stride1 got %h want 0001", v); end
  endtask

  task automatic test_random;
    bit             we, re;
    logic [3:0]     a;
    logic [15:0]    d;
    logic [NCH-1:0] pops;
    int             r;
    do_reset();
    for (int cyc = 0; cyc < 1200; cyc++) begin
      we = 1'b0; re = 1'b0;
      r  = int'($urandom_range(0, 9));
      d  = 16'($urandom);
      a  = 4'($urandom);
      if (r < 4) begin
        we = 1'b1;
        a  = {1'b0, 1'($urandom_range(0, 1)), 2'b11};
      end else if (r == 4) begin
        we = 1'b1;
        if ((d[15:12] != 4'h0) && (a[1:0] == 2'b10)) d = 16'($urandom_range(0, 8));
      end else if (r < 7) begin
        re = 1'b1;
      end
      // Alternate fill-heavy and drain-heavy phases to reach full and empty
      if ((cyc / 150) % 2 == 0) pops = NCH'($urandom_range(0, 15) == 0 ? $urandom : 0);
      else                      pops = NCH'($urandom);
      step(we, re, a, d, pops);
      for (int c = 0; c < NCH; c++) begin
        n_cmp++;
        if (ch_valid[c] !== (mq[c].size() != 0)) begin
          n_bad++;
          $display("FAIL rnd_valid ch%0d cyc%0d got %b want %0d", c, cyc, ch_valid[c], mq[c].size() != 0);
        end else if (mq[c].size() != 0) begin
          n_cmp++;
          if (ch_data[c*DW +: DW] !== mq[c][0].d || ch_addr[c*AW +: AW] !== mq[c][0].a) begin
            n_bad++;
            $display("FAIL rnd_head ch%0d cyc%0d got %h@%h want %h@%h", c, cyc, ch_data[c*DW +: DW], ch_addr[c*AW +: AW], mq[c][0].d, mq[c][0].a);
          end
        end
      end
      n_cmp++;
      if (irq !== m_irq) begin n_bad++; $display("FAIL rnd_irq cyc%0d got %b want %b", cyc, irq, m_irq); end
      if (re) begin
        n_cmp++;
        if (to_cpu !== m_rd) begin n_bad++; $display("FAIL rnd_read a=%h cyc%0d got %h want %h", a, cyc, to_cpu, m_rd); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stride_stream();
    test_overflow();
    test_full_pop();
    test_irq();
    test_isolation_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/xgri_mc.md
# xgri_mc

Multi-channel CPU-to-graphics write-queue interface, the parametrised successor of the two-channel pattern/attribute register interface. The CPU programs a per-channel target address and stride, then streams data words into a channel's data port. Each word is queued together with its computed target address, and the address register auto-advances by the stride on every accepted push. The consumer (graphics memory manager) drains each channel through a show-ahead valid/pop port. Overflow tracking and a drain-complete interrupt are provided per channel.

## Interface
Parameters:
- NUM_CH, 2, number of channels (1..4).
- DATA_W, 16, data word width (fixed 16; CPU bus width).
- ADDR_W, 13, target address width (1..16).
- FIFO_DEPTH, 16, entries per channel (power of two, 2..128).

Ports:
- clk_sys  in  1  system clock; single clock domain.
- rst_n  in  1  reset; synchronous, active-low.
- ri_en  in  1  register-interface select.
- ri_wren  in  1  write strobe (qualified by ri_en).
- ri_ren  in  1  read strobe (qualified by ri_en).
- ri_addr  in  4  register address; [3:2] = channel, [1:0] = register.
- from_cpu  in  16  write data.
- to_cpu  out  16  registered read data.
- ch_valid  out  NUM_CH  channel head entry valid (FIFO non-empty).
- ch_pop  in  NUM_CH  consumer pops the head entry.
- ch_data  out  NUM_CH*DATA_W  head data; channel c occupies bits [c*DATA_W +: DATA_W].
- ch_addr  out  NUM_CH*ADDR_W  head target address; channel c occupies bits [c*ADDR_W +: ADDR_W].
- irq  out  1  OR over channels of (irq_pend & irq_en).

## Operation
Per-channel register map (reg = ri_addr[1:0]):
- 0 STATUS/CTRL.
  - Read: [15:8] level, [4] irq_en, [3] irq_pend, [2] ovf, [1] full, [0] empty.
  - Write: bit4 sets irq_en; bit3 = 1 clears irq_pend; bit2 = 1 clears ovf. Other bits are ignored.
- 1 ADDR.
  - Read/write of the next target address. Uses from_cpu[ADDR_W-1:0]; read is zero-extended.
- 2 STRIDE.
  - Read/write; ADDR_W bits. Reset value 1. A stride of 0 holds the address constant.
- 3 DATA.
  - A write is a push of the entry {ADDR, from_cpu}.
  - A read returns 0.

Push rules:
- A push is accepted if the channel is not full, or if ch_pop for that channel is asserted in the same cycle. In the second case the level is unchanged.
- On an accepted push, ADDR <= (ADDR + STRIDE) mod 2^ADDR_W.
- A push that is not accepted is dropped: ovf is set (sticky), and ADDR and the FIFO are unchanged.

Pop and interrupt rules:
- A pop while empty is ignored.
- irq_pend is set on the cycle the level goes from 1 to 0 (the pop of the last entry with no simultaneous push). It stays set until written 1 to clear.
- If a set event and a clear write coincide, the set wins.

Channel addressing:
- Channels >= NUM_CH ignore writes and read as 0.
- Writes to ADDR or STRIDE do not affect entries already queued.

Reset (rst_n = 0 at a clk_sys edge):
- to_cpu = 0; all FIFOs empty (ch_valid = 0, ch_data = 0, ch_addr = 0); ADDR = 0; STRIDE = 1; ovf, irq_pend, irq_en = 0; irq = 0.
- Reset asserted mid-stream discards all queued entries.

## Timing
- Reads:
  - to_cpu updates one cycle after a cycle with ri_en & ri_ren, and holds its value otherwise.
  - The status read shows the state sampled in the read cycle, before that cycle's push or pop.
- Push:
  - A push in cycle N makes ch_valid = 1, with data and address, at cycle N+1.
  - The ADDR readback is incremented from N+1.
- Pop:
  - ch_data and ch_addr are show-ahead.
  - A pop in cycle N presents the next entry, or drops ch_valid, at N+1.
- irq is registered: it asserts the cycle after irq_pend & irq_en first holds.
- Throughput: one push and one pop per channel per cycle.

## Structure
- Package xgri_pkg holds:
  - register offsets (REG_STATUS = 0, REG_ADDR = 1, REG_STRIDE = 2, REG_DATA = 3);
  - status bit positions;
  - the typedef for the per-entry struct {addr, data}.
- Sub-module xgri_fifo: a single-clock show-ahead FIFO parametrised by width and depth, with outputs full, empty, level and pop-accept logic. It is instantiated NUM_CH times via generate.
- The top level holds register decode, per-channel ADDR/STRIDE/flags, the read mux and the irq OR.

## Test plan
- Reset then status read: STATUS reads 0x0001 for channel 0; STRIDE reads 1; irq = 0, ch_valid = 0.
- Stride stream: ADDR = 0x0100, STRIDE = 4, push 0xAAAA, 0xBBBB, 0xCCCC -> pops yield (0x0100, 0xAAAA), (0x0104, 0xBBBB), (0x0108, 0xCCCC); ADDR reads 0x010C.
- Overflow: with FIFO_DEPTH = 16, push 17 words with no pop -> 17th is dropped; STATUS = level 16, full = 1, ovf = 1; ADDR has advanced 16 strides only. Write 0x0004 -> ovf clears.
- Full with simultaneous pop: fill to 16, then push and pop in the same cycle -> push accepted, level stays 16, ovf = 0.
- Drain interrupt: irq_en = 1, push 2 words, pop both -> irq rises one cycle after the level reaches 0; write 0x0018 -> irq falls. Repeat with irq_en = 0 -> irq_pend = 1, irq = 0.
- Channel isolation and wrap: ADDR = 0x1FFF, STRIDE = 2 on channel 1 (ADDR_W = 13), push -> channel 1 ADDR reads 0x0001 and channel 0 is unaffected. Write to ri_addr 0xC with NUM_CH = 2 -> no effect, and it reads 0. Asserting rst_n mid-stream empties all channels.
